mem_sequencer: RTL and testbench

//  Next-generation SRAM sequencer for the dot-product datapath. Accepts LOAD/COMPUTE/UNLOAD(/CLEAR) commands

---
 rtl/mem_seq_pkg.sv | 25 ++
 rtl/mem_seq_delay_line.sv | 38 +++
 rtl/mem_sequencer.sv | 232 +++++++++++++++++++++++
 tb/tb_mem_sequencer.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_seq_pkg
//  Purpose  : Shared opcodes and FSM state encoding for the SRAM sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
package mem_seq_pkg;

    localparam logic [1:0] OP_LOAD    = 2'b00;
    localparam logic [1:0] OP_COMPUTE = 2'b01;
    localparam logic [1:0] OP_UNLOAD  = 2'b10;
    localparam logic [1:0] OP_CLEAR   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE         = 3'd0,
        S_LOAD         = 3'd1,
        S_COMP_ISSUE   = 3'd2,
        S_COMP_DRAIN   = 3'd3,
        S_UNLOAD       = 3'd4,
        S_UNLOAD_DRAIN = 3'd5,
        S_CLEAR        = 3'd6
    } state_e;

endpackage
`default_nettype wire

// File: rtl/mem_seq_delay_line.sv
`default_nettype none
// ============================================================================
//  Module   : mem_seq_delay_line
//  Purpose  : Fixed-depth shift register carrying {valid, payload}; a
//             synchronous flush clears every stage in one cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_seq_delay_line
    import mem_seq_pkg::*;
#(
    parameter int Depth = 1,
    parameter int Width = 1
) (
    input  logic             clk,
    input  logic             Reset_n,
    input  logic             flush_i,
    input  logic [Width-1:0] data_i,
    output logic [Width-1:0] data_o
);

    logic [Width-1:0] stage_q [Depth];

    // Shift one stage per cycle; flush empties the whole line.
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < Depth; i++) stage_q[i] <= '0;
        end else if (flush_i) begin
            for (int i = 0; i < Depth; i++) stage_q[i] <= '0;
        end else begin
            stage_q[0] <= data_i;
            for (int i = 1; i < Depth; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign data_o = stage_q[Depth-1];

endmodule
`default_nettype wire

// File: rtl/mem_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : mem_sequencer
//  Purpose  : SRAM sequencer for the dot-product datapath. Runs LOAD /
//             COMPUTE / UNLOAD (and optionally CLEAR) sweeps over the input
//             and output SRAMs, aligning write-back with read latency plus
//             pipeline depth. Optional feature macro: MEM_SEQ_CLEAR_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_sequencer
    import mem_seq_pkg::*;
#(
    parameter int Addr_Width           = 4,
    parameter int Nums_SRAM_In         = 2,
    parameter int Nums_SRAM_Out        = 1,
    parameter int Read_Latency         = 1,
    parameter int Nums_Pipeline_Stages = 4
) (
    input  logic                                                clk,
    input  logic                                                Reset_n,
    input  logic                                                Cmd_valid,
    input  logic [1:0]                                          Cmd_op,
    input  logic [Addr_Width:0]                                 Cmd_len,
    input  logic                                                Abort,
    output logic                                                Cmd_ready,
    output logic                                                Busy,
    output logic                                                Done,
    output logic                                                Err,
    output logic [Nums_SRAM_In+Nums_SRAM_Out-1:0]               En_Chip_Select,
    output logic [Nums_SRAM_In+Nums_SRAM_Out-1:0]               En_Read,
    output logic [Nums_SRAM_In+Nums_SRAM_Out-1:0]               En_Write,
    output logic [(Nums_SRAM_In+Nums_SRAM_Out)*Addr_Width-1:0]  Addr_Read,
    output logic [(Nums_SRAM_In+Nums_SRAM_Out)*Addr_Width-1:0]  Addr_Write,
    output logic                                                Load_Req,
    output logic                                                Pipe_Valid,
    output logic                                                Unload_Valid,
    output logic [Addr_Width-1:0]                               Unload_Addr,
    output logic                                                Wr_Zero
);

    localparam int                NUMS_SRAM = Nums_SRAM_In + Nums_SRAM_Out;
    localparam int                WB_DEPTH  = Read_Latency + Nums_Pipeline_Stages;
    localparam logic [Addr_Width:0] LEN_MAX = {1'b1, {Addr_Width{1'b0}}};
    localparam logic [Addr_Width:0] CNT_ONE = (Addr_Width+1)'(1);

    state_e                  state_q, state_d;
    logic [Addr_Width:0]     cnt_q, cnt_d, len_q, len_d, w_len_m1;
    logic                    ld_q, ld_d, iss_q, iss_d, ul_q, ul_d, clr_q, clr_d;
    logic [Addr_Width-1:0]   ld_addr_q, ld_addr_d, iss_addr_q, iss_addr_d;
    logic [Addr_Width-1:0]   ul_addr_q, ul_addr_d, clr_addr_q, clr_addr_d;
    logic                    done_q, done_d, err_q, err_d, ready_q, ready_d, busy_q, busy_d;
    logic                    w_abort, w_len_ok, w_last;
    logic                    w_rl_v, w_rl_unl, w_wb_v;
    logic [Addr_Width-1:0]   w_rl_addr, w_wb_addr;
    logic [NUMS_SRAM-1:0]    w_we, w_re;

    assign w_abort  = Abort && (state_q != S_IDLE);
    assign w_len_ok = (Cmd_len != '0) && (Cmd_len <= LEN_MAX);
    assign w_len_m1 = len_q - CNT_ONE;
    assign w_last   = (cnt_q == w_len_m1);

    // Next-state, sweep counter and next-cycle output decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (Cmd_valid) begin
                    if (Cmd_op == OP_CLEAR) begin
`ifdef MEM_SEQ_CLEAR_EN
                        state_d = S_CLEAR;
                        cnt_d   = '0;
                        len_d   = LEN_MAX;
`else
                        err_d   = 1'b1;
`endif
                    end else if (!w_len_ok) begin
                        err_d = 1'b1;
                    end else begin
                        cnt_d = '0;
                        len_d = Cmd_len;
                        case (Cmd_op)
                            OP_LOAD:    state_d = S_LOAD;
                            OP_COMPUTE: state_d = S_COMP_ISSUE;
                            default:    state_d = S_UNLOAD;
                        endcase
                    end
                end
            end
            S_LOAD, S_CLEAR: begin
                if (w_last) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_COMP_ISSUE: begin
                if (w_last) state_d = S_COMP_DRAIN;
                else        cnt_d   = cnt_q + CNT_ONE;
            end
            S_UNLOAD: begin
                if (w_last) state_d = S_UNLOAD_DRAIN;
                else        cnt_d   = cnt_q + CNT_ONE;
            end
            // Finish once the write-back tap shows the last element.
            S_COMP_DRAIN: begin
                if (w_wb_v && ({1'b0, w_wb_addr} == w_len_m1)) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            S_UNLOAD_DRAIN: begin
                if (w_rl_v && w_rl_unl && ({1'b0, w_rl_addr} == w_len_m1)) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort beats a coincident completion.
        if (w_abort) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
            err_d   = 1'b1;
        end

        ld_d       = (state_d == S_LOAD);
        iss_d      = (state_d == S_COMP_ISSUE);
        ul_d       = (state_d == S_UNLOAD);
        clr_d      = (state_d == S_CLEAR);
        ld_addr_d  = ld_d  ? cnt_d[Addr_Width-1:0] : '0;
        iss_addr_d = iss_d ? cnt_d[Addr_Width-1:0] : '0;
        ul_addr_d  = ul_d  ? cnt_d[Addr_Width-1:0] : '0;
        clr_addr_d = clr_d ? cnt_d[Addr_Width-1:0] : '0;
        ready_d    = (state_d == S_IDLE);
        busy_d     = (state_d != S_IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            len_q      <= '0;
            ld_q       <= 1'b0;
            iss_q      <= 1'b0;
            ul_q       <= 1'b0;
            clr_q      <= 1'b0;
            ld_addr_q  <= '0;
            iss_addr_q <= '0;
            ul_addr_q  <= '0;
            clr_addr_q <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            ld_q       <= ld_d;
            iss_q      <= iss_d;
            ul_q       <= ul_d;
            clr_q      <= clr_d;
            ld_addr_q  <= ld_addr_d;
            iss_addr_q <= iss_addr_d;
            ul_addr_q  <= ul_addr_d;
            clr_addr_q <= clr_addr_d;
            done_q     <= done_d;
            err_q      <= err_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
        end
    end

    // Read-latency tap: shared by compute operands and unload data, tagged by mode.
    // Payloads are zero when not valid, so OR-merging the address fields is safe.
    mem_seq_delay_line #(.Depth(Read_Latency), .Width(Addr_Width + 2)) u_rl_tap (
        .clk     (clk),
        .Reset_n (Reset_n),
        .flush_i (w_abort),
        .data_i  ({iss_q | ul_q, ul_q, iss_addr_q | ul_addr_q}),
        .data_o  ({w_rl_v, w_rl_unl, w_rl_addr})
    );

    // Write-back tap: output-SRAM write lands latency + pipeline depth after issue.
    mem_seq_delay_line #(.Depth(WB_DEPTH), .Width(Addr_Width + 1)) u_wb_tap (
        .clk     (clk),
        .Reset_n (Reset_n),
        .flush_i (w_abort),
        .data_i  ({iss_q, iss_addr_q}),
        .data_o  ({w_wb_v, w_wb_addr})
    );

    for (genvar k = 0; k < NUMS_SRAM; k++) begin : g_sram
        if (k < Nums_SRAM_In) begin : g_in
            assign w_we[k] = ld_q;
            assign w_re[k] = iss_q;
            assign Addr_Write[k*Addr_Width +: Addr_Width] = ld_addr_q;
            assign Addr_Read [k*Addr_Width +: Addr_Width] = iss_addr_q;
        end else begin : g_out
            assign w_we[k] = w_wb_v | clr_q;
            assign w_re[k] = ul_q;
            assign Addr_Write[k*Addr_Width +: Addr_Width] = w_wb_addr | clr_addr_q;
            assign Addr_Read [k*Addr_Width +: Addr_Width] = ul_addr_q;
        end
    end

    assign En_Write       = w_we;
    assign En_Read        = w_re;
    assign En_Chip_Select = w_we | w_re;
    assign Cmd_ready      = ready_q;
    assign Busy           = busy_q;
    assign Done           = done_q;
    assign Err            = err_q;
    assign Load_Req       = ld_q;
    assign Pipe_Valid     = w_rl_v & ~w_rl_unl;
    assign Unload_Valid   = w_rl_v & w_rl_unl;
    assign Unload_Addr    = w_rl_addr & {Addr_Width{w_rl_unl}};
`ifdef MEM_SEQ_CLEAR_EN
    assign Wr_Zero        = clr_q;
`else
    assign Wr_Zero        = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_sequencer
//  Purpose  : Directed self-checking bench for mem_sequencer; instance A uses
//             default parameters, instance B uses Read_Latency=2.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_sequencer;

    logic        clk = 1'b0;
    logic        Reset_n;
    logic        valid_a, valid_b, abort;
    logic [1:0]  op;
    logic [4:0]  len;

    logic        a_rdy, a_busy, a_done, a_err, a_lreq, a_pv, a_uv, a_wz;
    logic [2:0]  a_cs, a_re, a_we;
    logic [11:0] a_ar, a_aw;
    logic [3:0]  a_ua;
    logic        b_rdy, b_busy, b_done, b_err, b_lreq, b_pv, b_uv, b_wz;
    logic [2:0]  b_cs, b_re, b_we;
    logic [11:0] b_ar, b_aw;
    logic [3:0]  b_ua;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_sequencer u_dut_a (
        .clk(clk), .Reset_n(Reset_n), .Cmd_valid(valid_a), .Cmd_op(op), .Cmd_len(len),
        .Abort(abort), .Cmd_ready(a_rdy), .Busy(a_busy), .Done(a_done), .Err(a_err),
        .En_Chip_Select(a_cs), .En_Read(a_re), .En_Write(a_we), .Addr_Read(a_ar),
        .Addr_Write(a_aw), .Load_Req(a_lreq), .Pipe_Valid(a_pv), .Unload_Valid(a_uv),
        .Unload_Addr(a_ua), .Wr_Zero(a_wz)
    );

    mem_sequencer #(.Read_Latency(2)) u_dut_b (
        .clk(clk), .Reset_n(Reset_n), .Cmd_valid(valid_b), .Cmd_op(op), .Cmd_len(len),
        .Abort(abort), .Cmd_ready(b_rdy), .Busy(b_busy), .Done(b_done), .Err(b_err),
        .En_Chip_Select(b_cs), .En_Read(b_re), .En_Write(b_we), .Addr_Read(b_ar),
        .Addr_Write(b_aw), .Load_Req(b_lreq), .Pipe_Valid(b_pv), .Unload_Valid(b_uv),
        .Unload_Addr(b_ua), .Wr_Zero(b_wz)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s @%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a command for one cycle; returns in the first access cycle.
    task automatic issue(input logic [1:0] o, input logic [4:0] l, input bit to_b);
        op  = o;
        len = l;
        if (to_b) valid_b = 1'b1; else valid_a = 1'b1;
        step();
        valid_a = 1'b0;
        valid_b = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        Reset_n = 1'b0; valid_a = 1'b0; valid_b = 1'b0; abort = 1'b0; op = 2'b00; len = 5'd0;
        step(); step();
        chk("rst_ready", 32'(a_rdy), 1);
        chk("rst_busy",  32'(a_busy), 0);
        chk("rst_flags", 32'({a_done, a_err, a_lreq, a_pv, a_uv, a_wz}), 0);
        chk("rst_en",    32'({a_cs, a_re, a_we}), 0);
        @(negedge clk) Reset_n = 1'b1;
        step();

        // LOAD len=16: both input SRAMs written 0..15
        issue(2'b00, 5'd16, 1'b0);
        for (int c = 0; c < 16; c++) begin
            chk("load_we",   32'(a_we), 3'b011);
            chk("load_cs",   32'(a_cs), 3'b011);
            chk("load_aw",   32'(a_aw), (c << 4) | c);
            chk("load_req",  32'(a_lreq), 1);
            chk("load_done", 32'(a_done), 0);
            step();
        end
        chk("load_done_pulse", 32'(a_done), 1);
        chk("load_we_off",     32'(a_we), 0);
        chk("load_busy_off",   32'(a_busy), 0);
        step();
        chk("load_done_clear", 32'(a_done), 0);

        // COMPUTE len=5, with a stray command while busy
        issue(2'b01, 5'd5, 1'b0);
        for (int c = 0; c < 12; c++) begin
            chk("comp_re",   32'(a_re), (c < 5) ? 3 : 0);
            chk("comp_ar",   32'(a_ar), (c < 5) ? ((c << 4) | c) : 0);
            chk("comp_pv",   32'(a_pv), (c >= 1 && c <= 5) ? 1 : 0);
            chk("comp_we",   32'(a_we), (c >= 5 && c <= 9) ? 4 : 0);
            chk("comp_aw",   32'(a_aw), (c >= 5 && c <= 9) ? ((c - 5) << 8) : 0);
            chk("comp_done", 32'(a_done), (c == 10) ? 1 : 0);
            chk("comp_busy", 32'(a_busy), (c < 10) ? 1 : 0);
            chk("comp_err",  32'(a_err), 0);
            if (c == 2) begin
                chk("comp_ready_busy", 32'(a_rdy), 0);
                op = 2'b00; len = 5'd4; valid_a = 1'b1;
            end
            if (c == 3) valid_a = 1'b0;
            step();
        end

        // UNLOAD len=3 on the Read_Latency=2 instance
        issue(2'b10, 5'd3, 1'b1);
        for (int c = 0; c < 7; c++) begin
            chk("unl_re",   32'(b_re), (c < 3) ? 4 : 0);
            chk("unl_ar",   32'(b_ar), (c < 3) ? (c << 8) : 0);
            chk("unl_uv",   32'(b_uv), (c >= 2 && c <= 4) ? 1 : 0);
            chk("unl_ua",   32'(b_ua), (c >= 2 && c <= 4) ? (c - 2) : 0);
            chk("unl_pv",   32'(b_pv), 0);
            chk("unl_done", 32'(b_done), (c == 5) ? 1 : 0);
            step();
        end

        // Illegal lengths: Err only
        issue(2'b00, 5'd0, 1'b0);
        chk("len0_err",  32'(a_err), 1);
        chk("len0_busy", 32'(a_busy), 0);
        chk("len0_en",   32'({a_cs, a_we, a_re}), 0);
        step();
        chk("len0_err_clear", 32'(a_err), 0);
        issue(2'b01, 5'd17, 1'b0);
        chk("len17_err",  32'(a_err), 1);
        chk("len17_busy", 32'(a_busy), 0);
        chk("len17_en",   32'({a_cs, a_we, a_re}), 0);
        step();
        chk("len17_err_clear", 32'(a_err), 0);
        chk("len17_idle", 32'({a_cs, a_busy}), 0);

        // Abort after three compute issues
        issue(2'b01, 5'd8, 1'b0);
        for (int c = 0; c < 3; c++) begin
            chk("abt_re", 32'(a_re), 3);
            chk("abt_ar", 32'(a_ar), (c << 4) | c);
            if (c == 2) abort = 1'b1;
            step();
        end
        abort = 1'b0;
        chk("abt_err",  32'(a_err), 1);
        chk("abt_busy", 32'(a_busy), 0);
        chk("abt_en",   32'({a_cs, a_re, a_we, a_pv}), 0);
        chk("abt_done", 32'(a_done), 0);
        for (int c = 0; c < 12; c++) begin
            step();
            chk("abt_quiet", 32'({a_we, a_pv, a_done, a_err}), 0);
        end

        // Async reset in the middle of LOAD
        issue(2'b00, 5'd16, 1'b0);
        step(); step(); step(); step();
        chk("mid_load_active", 32'(a_we), 3);
        Reset_n = 1'b0;
        #1;
        chk("arst_we",    32'(a_we), 0);
        chk("arst_req",   32'(a_lreq), 0);
        chk("arst_aw",    32'(a_aw), 0);
        chk("arst_busy",  32'(a_busy), 0);
        chk("arst_ready", 32'(a_rdy), 1);
        @(negedge clk) Reset_n = 1'b1;
        step();
        chk("arst_stay_idle", 32'({a_we, a_busy}), 0);

        // CLEAR (length field ignored)
        issue(2'b11, 5'd5, 1'b0);
`ifdef MEM_SEQ_CLEAR_EN
        for (int c = 0; c < 16; c++) begin
            chk("clr_we", 32'(a_we), 4);
            chk("clr_aw", 32'(a_aw), c << 8);
            chk("clr_wz", 32'(a_wz), 1);
            step();
        end
        chk("clr_done", 32'(a_done), 1);
        chk("clr_off",  32'({a_we, a_wz}), 0);
`else
        chk("clr_err",  32'(a_err), 1);
        chk("clr_busy", 32'(a_busy), 0);
        chk("clr_en",   32'({a_we, a_wz}), 0);
        step();
        chk("clr_err_clear", 32'({a_err, a_done}), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
